// File: rtl/sr_vcu_regs_if.sv
// CPU register bus for the sr_cpu_vc video control unit.
// The CPU drives control/data strobes; the VCU returns packed status.
interface sr_vcu_regs_if;
  logic [31:0] vcu_reg_control;
  logic        vcu_reg_control_we;
  logic [31:0] vcu_reg_wdata;
  logic        vcu_reg_wdata_we;
  logic [31:0] vcu_reg_rdata;

  modport master (
    output vcu_reg_control,
    output vcu_reg_control_we,
    output vcu_reg_wdata,
    output vcu_reg_wdata_we,
    input  vcu_reg_rdata
  );

  modport slave (
    input  vcu_reg_control,
    input  vcu_reg_control_we,
    input  vcu_reg_wdata,
    input  vcu_reg_wdata_we,
    output vcu_reg_rdata
  );
endinterface

// File: rtl/sr_vcu_regs.sv
// VCU register responder: character buffer, write pointer,
// hardware clear sweep, tick timer and display scan port.
module sr_vcu_regs #(
  parameter int DEPTH = 16,
  parameter int TICK_W = 28,
  parameter logic [TICK_W-1:0] TICK_LOAD = TICK_W'(32'h02FAF080),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  sr_vcu_regs_if.slave  bus,
  input  logic [AW-1:0] scan_addr,
  output logic [7:0]    scan_data
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state;
  logic [AW-1:0]   ptr;
  logic [AW-1:0]   idx;
  logic [7:0]      fill;
  logic            autoinc;
  logic            drop;
  logic [TICK_W-1:0] timer;
  logic [7:0]      mem [DEPTH];

  logic [1:0] cmd;
  logic       is_set;
  logic       is_clr;
  logic       is_ack;
  logic       reload;
  logic       busy;
  logic       tick;
  logic       do_wr;
  logic       drop_ev;
  logic [AW-1:0] ptr_inc;

  always_comb begin
    cmd     = bus.vcu_reg_control[11:10];
    is_set  = bus.vcu_reg_control_we && (cmd == 2'b00);
    is_clr  = bus.vcu_reg_control_we && (cmd == 2'b01);
    is_ack  = bus.vcu_reg_control_we && (cmd == 2'b10);
    busy    = (state == CLEAR);
    tick    = (timer == '0);
    do_wr   = bus.vcu_reg_wdata_we && !busy;
    drop_ev = bus.vcu_reg_wdata_we && busy;
    reload  = bus.vcu_reg_wdata_we ||
              (bus.vcu_reg_control_we && bus.vcu_reg_control[9]);
    ptr_inc = (do_wr && autoinc) ? ptr + 1'b1 : ptr;
  end

  // CPU writes cannot collide with the sweep: they are dropped while busy.
  always_ff @(posedge clk) begin
    if (busy)
      mem[idx] <= fill;
    else if (do_wr)
      mem[ptr] <= bus.vcu_reg_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      idx     <= '0;
      fill    <= '0;
      autoinc <= 1'b0;
      drop    <= 1'b0;
      timer   <= TICK_LOAD;
    end else begin
      unique case (1'b1)
        is_set: begin
          ptr     <= bus.vcu_reg_control[AW-1:0];
          autoinc <= bus.vcu_reg_control[8];
        end
        is_clr:  ptr <= '0;
        default: ptr <= ptr_inc;
      endcase

      if (is_clr) begin
        state <= CLEAR;
        idx   <= '0;
        fill  <= bus.vcu_reg_control[23:16];
      end else if (busy) begin
        idx <= idx + 1'b1;
        if (idx == AW'(DEPTH - 1))
          state <= IDLE;
      end

      if (drop_ev)
        drop <= 1'b1;
      else if (is_ack)
        drop <= 1'b0;

      if (reload)
        timer <= TICK_LOAD;
      else if (!tick)
        timer <= timer - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.vcu_reg_rdata <= '0;
      scan_data         <= '0;
    end else begin
      bus.vcu_reg_rdata <= {8'h00, mem[ptr], 8'(ptr),
                            5'b0, drop, busy, tick};
      scan_data         <= mem[scan_addr];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.vcu_reg_control, bus.vcu_reg_wdata};

endmodule

// File: doc/sr_vcu_regs.md
Name: sr_vcu_regs

Overview:
- CPU-side responder for the sr_cpu_vc video control unit (VCU) register interface.
- Consumes vcu_reg_control / vcu_reg_wdata write strobes and owns a DEPTH x 8-bit character buffer with a write pointer and a hardware clear engine.
- Contains a reloadable tick timer and returns packed status on vcu_reg_rdata.
- Provides a registered scan read port for the display/video path.

Parameters:
- DEPTH, 16, buffer entries; power of two, 2..256; AW = $clog2(DEPTH).
- TICK_W, 28, tick timer width.
- TICK_LOAD, 28'h2FAF080, timer reload value (tick period in clk cycles); benches use a small value, e.g. 16.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- vcu_reg_control  in  32  control word from CPU.
- vcu_reg_control_we  in  1  1 = vcu_reg_control valid this cycle.
- vcu_reg_wdata  in  32  data word from CPU; [7:0] is the character.
- vcu_reg_wdata_we  in  1  1 = vcu_reg_wdata valid this cycle.
- vcu_reg_rdata  out  32  packed status/read data to CPU.
- scan_addr  in  AW  display read address.
- scan_data  out  8  buffer[scan_addr], registered.

Behaviour:
- Reset (async, rst_n=0):
  - ptr=0, autoinc=0, state=IDLE, drop=0, timer=TICK_LOAD.
  - vcu_reg_rdata=0, scan_data=0.
  - Buffer contents are undefined until the first clear.
- Control word fields:
  - [7:0] ptr value.
  - [8] autoinc.
  - [9] timer restart.
  - [11:10] cmd.
  - [23:16] fill byte.
- Commands on control_we, by cmd:
  - 00 SET: ptr <= ctrl[AW-1:0] (upper bits ignored); autoinc <= ctrl[8].
  - 01 CLEAR: enter CLEAR state; sweep index <= 0; fill <= ctrl[23:16]; ptr <= 0.
  - 10 ACK: drop <= 0.
  - 11: no-op.
  - ctrl[9]=1 reloads the timer regardless of cmd.
- Data write (wdata_we in IDLE):
  - buffer[ptr] <= wdata[7:0].
  - If autoinc, ptr <= ptr+1, wrapping DEPTH-1 -> 0.
  - Timer reloads to TICK_LOAD.
- States:
  - IDLE: accepts writes.
  - CLEAR: writes buffer[idx] <= fill, one entry per cycle, idx 0..DEPTH-1. Exactly DEPTH cycles, then returns to IDLE; busy=1 throughout.
- Writes during CLEAR:
  - wdata_we is not written, ptr does not move, and drop <= 1 (sticky).
  - The timer still reloads.
- CLEAR while already in CLEAR: restarts the sweep at idx 0 with the new fill byte.
- Same-cycle control_we and wdata_we:
  - The data write uses the pre-update ptr.
  - Then the control update applies; a SET ptr overrides the increment.
  - A same-cycle CLEAR takes effect after the data write, so that write is not dropped.
- Same-cycle SET and CLEAR are impossible (single cmd field).
- Timer:
  - Decrements by 1 per cycle while nonzero; holds at 0.
  - tick = (timer==0).
  - A reload in the same cycle as reaching 0 wins, so tick stays 0.
- vcu_reg_rdata, registered, 1-cycle latency from the state it reflects:
  - [0] tick.
  - [1] busy.
  - [2] drop.
  - [15:8] ptr, zero-extended.
  - [23:16] buffer[ptr].
  - All other bits 0.
- Scan port:
  - scan_data <= buffer[scan_addr] each cycle (1-cycle latency).
  - In the cycle a buffer entry is written, scan_data returns the old value (read-before-write).
  - Scanning is never blocked by CLEAR or CPU writes.
- Implementation target: synchronous-read RAM inference is permitted; the rdata[23:16] path may use a second read port.

Test Plan:
1. Reset, then SET ctrl=0x00000105 (ptr=5, autoinc=1); write wdata 0x41, 0x42 → ptr=7. scan_addr=5/6 gives 0x41/0x42 one cycle later. rdata[15:8]=0x07.
2. SET ptr=DEPTH-1 with autoinc; write 0x55 twice → buffer[15]=0x55, buffer[0]=0x55, ptr wraps to 1.
3. CLEAR with fill 0x20 (ctrl=0x00200400) → busy=1 for exactly 16 cycles. Every entry reads 0x20; ptr=0; rdata[1] falls one cycle after the sweep ends.
4. wdata_we at the 3rd CLEAR cycle → buffer unchanged (0x20), rdata[2]=1 and sticky. ACK (ctrl=0x00000800) → rdata[2]=0.
5. TICK_LOAD=16: after reset, rdata[0]=0 for 16 cycles, then 1. A wdata_we clears tick and it re-asserts 16 cycles later. A ctrl[9] restart with cmd=11 behaves the same.
6. Same-cycle wdata_we=0x33 and SET ptr=9 while ptr=2 → buffer[2]=0x33, ptr=9. Assert rst_n=0 mid-CLEAR → busy=0, ptr=0, rdata=0 immediately (asynchronous).
